// File: rtl/adc_chan_framer_pkg.sv
// Shared encodings for the ADC channel framer: word tags, channel-select codes,
// FSM state encoding and the default sample width.
package adc_chan_framer_pkg;

   localparam int ADC_DATA_WIDTH_DEF = 12;

   // Tag field, top two bits of every output word
   localparam logic [1:0] TAG_HDR = 2'b00;
   localparam logic [1:0] TAG_A   = 2'b01;
   localparam logic [1:0] TAG_B   = 2'b10;

   // chan_sel_i encodings
   localparam logic [1:0] SEL_OFF = 2'b00;
   localparam logic [1:0] SEL_A   = 2'b01;
   localparam logic [1:0] SEL_B   = 2'b10;
   localparam logic [1:0] SEL_AB  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/adc_chan_framer_sync_fifo.sv
// Purpose: first-word-fall-through FIFO, power-of-two depth, full/empty flags.
// Latency: a word written on one edge is visible at rd_dat_o right after that edge.
// Backpressure: a write while full succeeds only if a read happens on the same edge.
module adc_chan_framer_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_vld_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_rdy_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic             rd_en;

   // Extra pointer bit distinguishes full from empty when the indices match
   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en    = rd_rdy_i & ~empty_o;
   assign wr_en    = wr_vld_i & (~full_o | rd_en);
   // Zero while empty so the output word is defined out of reset
   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted write / read
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   // Pointer registers; reset discards all buffered words
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset needed since reads are gated by empty
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
   end

endmodule

// File: rtl/adc_chan_framer.sv
// Purpose: frames one FMCW ramp of tagged A/B samples into a FWFT FIFO; FRAMER_HEADER_EN adds a header word.
// Latency: sample_vld_i to out_vld_o is 2 cycles with an empty FIFO (B of a pair follows 1 cycle later).
// Backpressure: out_rdy_i only drains the FIFO; a full FIFO drops words and sets sticky overflow_o.
module adc_chan_framer
   import adc_chan_framer_pkg::*;
#(
   parameter int ADC_DATA_WIDTH   = ADC_DATA_WIDTH_DEF,
   parameter int SAMPLES_PER_RAMP = 20480,
   parameter int FIFO_DEPTH       = 1024,
   localparam int OUT_WIDTH       = ADC_DATA_WIDTH + 2
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      sample_vld_i,
   input  logic [ADC_DATA_WIDTH-1:0] chan_a_i,
   input  logic [ADC_DATA_WIDTH-1:0] chan_b_i,
   input  logic                      ramp_start_i,
   input  logic [1:0]                chan_sel_i,
   input  logic                      out_rdy_i,
   output logic [OUT_WIDTH-1:0]      out_data_o,
   output logic                      out_vld_o,
   output logic                      frame_start_o,
   output logic                      frame_end_o,
   output logic                      overflow_o,
   output logic                      busy_o
);

   localparam int CNT_W = (SAMPLES_PER_RAMP > 1) ? $clog2(SAMPLES_PER_RAMP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_RAMP - 1);
   localparam int ENT_W = OUT_WIDTH + 2;

   state_t               state_q, state_d;
   logic [1:0]           sel_q, sel_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 first_q, first_d;
   logic                 skid_vld_q, skid_vld_d;
   logic [OUT_WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic                 skid_end_q, skid_end_d;
   logic                 wr_vld_q, wr_vld_d;
   logic [OUT_WIDTH-1:0] wr_dat_q, wr_dat_d;
   logic                 wr_start_q, wr_start_d;
   logic                 wr_end_q, wr_end_d;
   logic                 ovf_q, ovf_d;
`ifdef FRAMER_HEADER_EN
   logic [7:0]           frm_cnt_q, frm_cnt_d;
`endif

   logic [ENT_W-1:0]     rd_ent;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_rd;
   logic                 fifo_drop;
   logic                 last_pair;

   assign last_pair = (cnt_q == CNT_LAST);
   assign fifo_rd   = ~fifo_empty & out_rdy_i;
   assign fifo_drop = wr_vld_q & fifo_full & ~fifo_rd;

   // Frame FSM, pair counter, skid register and write-stage staging
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      skid_vld_d = 1'b0;
      skid_dat_d = skid_dat_q;
      skid_end_d = skid_end_q;
      wr_vld_d   = 1'b0;
      wr_dat_d   = wr_dat_q;
      wr_start_d = 1'b0;
      wr_end_d   = 1'b0;
      ovf_d      = ovf_q | fifo_drop;
`ifdef FRAMER_HEADER_EN
      frm_cnt_d  = frm_cnt_q;
`endif
      // A pending B sample always takes the write stage first
      if (skid_vld_q) begin
         wr_vld_d = 1'b1;
         wr_dat_d = skid_dat_q;
         wr_end_d = skid_end_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (ramp_start_i && (chan_sel_i != SEL_OFF)) begin
               sel_d   = chan_sel_i;
               cnt_d   = '0;
               first_d = 1'b1;
`ifdef FRAMER_HEADER_EN
               // Header carries the start marker, so samples never do
               wr_vld_d   = 1'b1;
               wr_dat_d   = {TAG_HDR, ADC_DATA_WIDTH'({frm_cnt_q, chan_sel_i})};
               wr_start_d = 1'b1;
               first_d    = 1'b0;
               frm_cnt_d  = frm_cnt_q + 8'd1;
               state_d    = ST_HDR;
`else
               state_d    = ST_CAPTURE;
`endif
            end
         end
         // HDR captures like CAPTURE: the header was staged on the ramp edge
         ST_HDR, ST_CAPTURE: begin
            if (sample_vld_i) begin
               if (skid_vld_q) begin
                  // Strobe while B still pending: the pair is lost
                  ovf_d = 1'b1;
               end else begin
                  case (sel_q)
                     SEL_A: begin
                        wr_vld_d   = 1'b1;
                        wr_dat_d   = {TAG_A, chan_a_i};
                        wr_start_d = first_q;
                        wr_end_d   = last_pair;
                     end
                     SEL_B: begin
                        wr_vld_d   = 1'b1;
                        wr_dat_d   = {TAG_B, chan_b_i};
                        wr_start_d = first_q;
                        wr_end_d   = last_pair;
                     end
                     default: begin
                        wr_vld_d   = 1'b1;
                        wr_dat_d   = {TAG_A, chan_a_i};
                        wr_start_d = first_q;
                        skid_vld_d = 1'b1;
                        skid_dat_d = {TAG_B, chan_b_i};
                        skid_end_d = last_pair;
                     end
                  endcase
                  first_d = 1'b0;
               end
               // Counter advances even on drops to keep frame length in time
               if (last_pair) begin
                  cnt_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards the frame in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         sel_q      <= SEL_OFF;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
         skid_end_q <= 1'b0;
         wr_vld_q   <= 1'b0;
         wr_dat_q   <= '0;
         wr_start_q <= 1'b0;
         wr_end_q   <= 1'b0;
         ovf_q      <= 1'b0;
`ifdef FRAMER_HEADER_EN
         frm_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
         skid_end_q <= skid_end_d;
         wr_vld_q   <= wr_vld_d;
         wr_dat_q   <= wr_dat_d;
         wr_start_q <= wr_start_d;
         wr_end_q   <= wr_end_d;
         ovf_q      <= ovf_d;
`ifdef FRAMER_HEADER_EN
         frm_cnt_q  <= frm_cnt_d;
`endif
      end
   end

   adc_chan_framer_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_vld_i (wr_vld_q),
      .wr_dat_i ({wr_start_q, wr_end_q, wr_dat_q}),
      .rd_rdy_i (out_rdy_i),
      .rd_dat_o (rd_ent),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty)
   );

   assign out_vld_o     = ~fifo_empty;
   assign out_data_o    = rd_ent[OUT_WIDTH-1:0];
   assign frame_start_o = rd_ent[ENT_W-1];
   assign frame_end_o   = rd_ent[ENT_W-2];
   assign overflow_o    = ovf_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule
